// File: rtl/flippy_pkg.sv
// rtl/flippy_pkg.sv - shared constants and FSM encoding for the key entry block
//
// Contents:
//   DEBOUNCE_CYCLES_DEFAULT : stable-level cycles for a press/release (10 ms at 50 MHz)
//   state_t                 : key entry FSM state encoding
package flippy_pkg;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    PRESS_DB   = 3'd1,
    SUBMIT     = 3'd2,
    JUDGE      = 3'd3,
    HELD       = 3'd4,
    RELEASE_DB = 3'd5
  } state_t;

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchroniser for one asynchronous input bit
//
// Ports:
//   clock   : system clock
//   reset_n : asynchronous active-low reset; both flops load RST_VAL
//   d       : raw asynchronous input
//   q       : synchronised output, two clock edges behind d
module sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/key_entry.sv
// rtl/key_entry.sv - debounced guess submission with hit/miss scoring
//
// Ports:
//   clock        : system clock, rising edge
//   reset_n      : asynchronous active-low reset
//   switches     : raw slide-switch guess (ASCII)
//   submit_btn_n : raw active-low submit button
//   correct      : match flag for the presented guess, sampled in JUDGE
//   game_over    : game has ended; blocks new presses and freezes scores
//   user_input   : last submitted guess, held until the next submission
//   guess_valid  : one-cycle strobe qualifying user_input
//   hits         : saturating count of correct guesses
//   misses       : saturating count of wrong guesses
//   busy         : high in every state except IDLE
module key_entry
  import flippy_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int SCORE_W         = 8
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [7:0]         switches,
  input  logic               submit_btn_n,
  input  logic               correct,
  input  logic               game_over,
  output logic [7:0]         user_input,
  output logic               guess_valid,
  output logic [SCORE_W-1:0] hits,
  output logic [SCORE_W-1:0] misses,
  output logic               busy
);

  // The counter only has to hold DEBOUNCE_CYCLES-1, so $clog2 of the
  // cycle count is enough; guard the degenerate single-cycle case.
  localparam int                 CNT_W     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]   CNT_TERM  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  logic [7:0]       sw_sync;
  logic             btn_sync_n;
  logic             pressed;
  state_t           state;
  logic [CNT_W-1:0] cnt;

  for (genvar i = 0; i < 8; i++) begin : g_sw_sync
    sync2 #(.RST_VAL(1'b0)) u_sw_sync (
      .clock   (clock),
      .reset_n (reset_n),
      .d       (switches[i]),
      .q       (sw_sync[i])
    );
  end

  // Button idles high, so its synchroniser resets to the released level.
  sync2 #(.RST_VAL(1'b1)) u_btn_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (submit_btn_n),
    .q       (btn_sync_n)
  );

  assign pressed = ~btn_sync_n;
  assign busy    = (state != IDLE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      user_input  <= 8'h00;
      guess_valid <= 1'b0;
      hits        <= '0;
      misses      <= '0;
    end else begin
      guess_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (pressed && !game_over) begin
            state <= PRESS_DB;
            cnt   <= '0;
          end
        end
        PRESS_DB: begin
          // Game ending mid-debounce abandons the press.
          if (game_over || !pressed) begin
            state <= IDLE;
          end else if (cnt == CNT_TERM) begin
            // Strobe and data are registered on entry so both are valid
            // for exactly the SUBMIT cycle.
            state       <= SUBMIT;
            user_input  <= sw_sync;
            guess_valid <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        SUBMIT: begin
          state <= JUDGE;
        end
        JUDGE: begin
          if (!game_over) begin
            if (correct) begin
              if (hits != SCORE_MAX) hits <= hits + SCORE_W'(1);
            end else begin
              if (misses != SCORE_MAX) misses <= misses + SCORE_W'(1);
            end
          end
          state <= HELD;
        end
        HELD: begin
          if (!pressed) begin
            cnt   <= '0;
            state <= RELEASE_DB;
          end
        end
        RELEASE_DB: begin
          if (pressed) begin
            state <= HELD;
          end else if (cnt == CNT_TERM) begin
            state <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_entry.sv
// tb/tb_key_entry.sv - scoreboard bench for key_entry with DEBOUNCE_CYCLES=4
module tb_key_entry;

  logic       clock;
  logic       reset_n;
  logic [7:0] switches;
  logic       submit_btn_n;
  logic       correct;
  logic       game_over;
  logic [7:0] user_input;
  logic       guess_valid;
  logic [7:0] hits;
  logic [7:0] misses;
  logic       busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] ui;
    logic [7:0] h;
    logic [7:0] m;
  } exp_t;

  exp_t sb_q[$];

  int exp_hits   = 0;
  int exp_misses = 0;

  key_entry #(.DEBOUNCE_CYCLES(4), .SCORE_W(8)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .switches     (switches),
    .submit_btn_n (submit_btn_n),
    .correct      (correct),
    .game_over    (game_over),
    .user_input   (user_input),
    .guess_valid  (guess_valid),
    .hits         (hits),
    .misses       (misses),
    .busy         (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic summary();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
  endtask

  // Scoreboard monitor: every strobe must match the oldest expected entry,
  // and the scores must reflect the judgement two cycles later.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset_n && guess_valid) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_strobe", 1, 0);
        end else begin
          e = sb_q.pop_front();
          chk("sb_user_input", int'(user_input), int'(e.ui));
          @(negedge clock);
          @(negedge clock);
          chk("sb_hits", int'(hits), int'(e.h));
          chk("sb_misses", int'(misses), int'(e.m));
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    errors++;
    summary();
    $finish;
  end

  task automatic wait_idle();
    int n;
    n = 0;
    repeat (3) @(posedge clock);
    #1;
    while (busy && n < 40) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk("idle_reached", int'(busy), 0);
  endtask

  // Cycle 1 is the first rising edge after the button goes low.
  task automatic press(input logic [7:0] sw, input logic corr, input int hold, input int go_at,
                       output int first, output int npulse, output int busy_seen);
    @(negedge clock);
    switches     = sw;
    correct      = corr;
    submit_btn_n = 1'b0;
    first        = -1;
    npulse       = 0;
    busy_seen    = 0;
    for (int i = 1; i <= hold; i++) begin
      @(posedge clock);
      #1;
      if (guess_valid) begin
        npulse++;
        if (first < 0) first = i;
      end
      if (busy) busy_seen = 1;
      if (i == go_at) game_over = 1'b1;
    end
    submit_btn_n = 1'b1;
    wait_idle();
  endtask

  task automatic push_exp(input logic [7:0] sw, input logic corr);
    exp_t e;
    if (corr) exp_hits = (exp_hits == 255) ? 255 : exp_hits + 1;
    else      exp_misses = (exp_misses == 255) ? 255 : exp_misses + 1;
    e.ui = sw;
    e.h  = 8'(exp_hits);
    e.m  = 8'(exp_misses);
    sb_q.push_back(e);
  endtask

  initial begin
    int first, npulse, bseen;
    logic [7:0] sw;

    reset_n      = 1'b0;
    switches     = 8'h00;
    submit_btn_n = 1'b1;
    correct      = 1'b0;
    game_over    = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_user_input", int'(user_input), 0);
    chk("rst_guess_valid", int'(guess_valid), 0);
    chk("rst_hits", int'(hits), 0);
    chk("rst_misses", int'(misses), 0);
    chk("rst_busy", int'(busy), 0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(posedge clock);

    // Long press: single strobe at cycle 7, judged correct.
    push_exp(8'h41, 1'b1);
    press(8'h41, 1'b1, 20, -1, first, npulse, bseen);
    chk("latency_first_strobe", first, 7);
    chk("long_press_pulses", npulse, 1);

    // Wrong guess counts a miss.
    push_exp(8'h5A, 1'b0);
    press(8'h5A, 1'b0, 10, -1, first, npulse, bseen);
    chk("miss_press_pulses", npulse, 1);

    // Bounce shorter than debounce: no submission, scores unchanged.
    press(8'h33, 1'b1, 3, -1, first, npulse, bseen);
    chk("bounce_pulses", npulse, 0);
    chk("bounce_hits", int'(hits), 1);
    chk("bounce_misses", int'(misses), 1);
    chk("bounce_user_input", int'(user_input), 'h5A);

    // Press while game is over is ignored entirely.
    game_over = 1'b1;
    press(8'h77, 1'b1, 10, -1, first, npulse, bseen);
    chk("gameover_pulses", npulse, 0);
    chk("gameover_busy_seen", bseen, 0);
    game_over = 1'b0;
    repeat (2) @(posedge clock);

    // Game ends mid-debounce: press abandoned.
    press(8'h66, 1'b1, 10, 4, first, npulse, bseen);
    chk("go_mid_db_pulses", npulse, 0);
    chk("go_mid_db_busy_seen", bseen, 1);
    chk("go_mid_db_hits", int'(hits), 1);
    game_over = 1'b0;
    repeat (2) @(posedge clock);

    // Drive hits to saturation, then one more correct press.
    while (exp_hits < 255) begin
      sw = 8'(exp_hits);
      push_exp(sw, 1'b1);
      press(sw, 1'b1, 8, -1, first, npulse, bseen);
      chk("fill_pulses", npulse, 1);
    end
    push_exp(8'hEE, 1'b1);
    press(8'hEE, 1'b1, 8, -1, first, npulse, bseen);
    chk("sat_pulses", npulse, 1);
    chk("sat_hits", int'(hits), 255);
    chk("sat_misses", int'(misses), 1);

    // Reset pulse landing in the SUBMIT cycle.
    @(negedge clock);
    switches     = 8'hC3;
    correct      = 1'b1;
    submit_btn_n = 1'b0;
    repeat (7) @(posedge clock);
    #1;
    chk("submit_reached", int'(guess_valid), 1);
    reset_n = 1'b0;
    #1;
    chk("rst_submit_guess_valid", int'(guess_valid), 0);
    chk("rst_submit_user_input", int'(user_input), 0);
    chk("rst_submit_hits", int'(hits), 0);
    chk("rst_submit_misses", int'(misses), 0);
    chk("rst_submit_busy", int'(busy), 0);
    submit_btn_n = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (10) @(posedge clock);
    #1;
    chk("post_rst_busy", int'(busy), 0);
    chk("post_rst_hits", int'(hits), 0);
    chk("post_rst_misses", int'(misses), 0);

    repeat (5) @(posedge clock);
    chk("scoreboard_drained", sb_q.size(), 0);
    summary();
    $finish;
  end

endmodule
